// File: rtl/seg_scroll_monitor_if.sv
// Bus bundle for the 7-segment scroll monitor: sampled display inputs and the
// rebuilt-frame outputs. The master drives the display bus; the monitor is the slave.
interface seg_scroll_monitor_if;
  logic [7:0]  seg_in;
  logic [3:0]  an_in;
  logic [19:0] digit_code;
  logic [31:0] frame_seg;
  logic        frame_valid;
  logic        scroll_step;
  logic        bad_pattern;
  logic        an_error;
  logic        stale;
  logic [7:0]  scroll_count;

  modport master (
    output seg_in, an_in,
    input  digit_code, frame_seg, frame_valid, scroll_step,
           bad_pattern, an_error, stale, scroll_count
  );

  modport slave (
    input  seg_in, an_in,
    output digit_code, frame_seg, frame_valid, scroll_step,
           bad_pattern, an_error, stale, scroll_count
  );
endinterface

// File: rtl/seg_scroll_monitor.sv
// Passive monitor of a multiplexed 4-digit 7-segment bus: rebuilds frames,
// decodes characters and flags frames that are a one-character left scroll.
module seg_scroll_monitor #(
  parameter int SETTLE_CYCLES = 16,
  parameter int STALE_LIMIT   = 2000000,
  parameter int CNT_W         = 22
) (
  input  logic                basys_clock,
  input  logic                rst_n,
  seg_scroll_monitor_if.slave bus
);

  localparam int STB_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [STB_W-1:0] STB_SAT   = STB_W'(SETTLE_CYCLES);
  localparam logic [STB_W-1:0] STB_CAP   = STB_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(STALE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_M1  = CNT_W'(STALE_LIMIT - 1);
  localparam logic [4:0]       CODE_BAD  = 5'h1E;
  localparam logic [4:0]       CODE_BLK  = 5'h1F;

  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    case (s)
      7'h40:   return 5'h00;
      7'h79:   return 5'h01;
      7'h24:   return 5'h02;
      7'h30:   return 5'h03;
      7'h19:   return 5'h04;
      7'h12:   return 5'h05;
      7'h02:   return 5'h06;
      7'h78:   return 5'h07;
      7'h00:   return 5'h08;
      7'h10:   return 5'h09;
      7'h41:   return 5'h11;
      7'h46:   return 5'h12;
      7'h06:   return 5'h13;
      7'h3F:   return 5'h10;
      7'h7F:   return CODE_BLK;
      default: return CODE_BAD;
    endcase
  endfunction

  function automatic logic has_bad(input logic [3:0][4:0] codes);
    logic any;
    any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (codes[i] == CODE_BAD) any = 1'b1;
    end
    return any;
  endfunction

  // Stage p0: registered bus sample; stage p1: previous sample for stability compare
  logic [7:0] seg_p0_q, seg_p1_q;
  logic [3:0] an_p0_q, an_p1_q;

  always_ff @(posedge basys_clock or negedge rst_n) begin
    if (!rst_n) begin
      seg_p0_q <= 8'hFF;
      seg_p1_q <= 8'hFF;
      an_p0_q  <= 4'hF;
      an_p1_q  <= 4'hF;
    end else begin
      seg_p0_q <= bus.seg_in;
      seg_p1_q <= seg_p0_q;
      an_p0_q  <= bus.an_in;
      an_p1_q  <= an_p0_q;
    end
  end

  logic       legal, blank, illegal, same;
  logic [1:0] slot;

  always_comb begin
    legal = 1'b1;
    slot  = 2'd0;
    case (an_p0_q)
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: legal = 1'b0;
    endcase
    blank   = (an_p0_q == 4'hF);
    illegal = !legal && !blank;
    same    = (an_p0_q == an_p1_q) && (seg_p0_q == seg_p1_q);
  end

  // Settle counter, dwell lock and capture strobe
  logic [STB_W-1:0] stb_q, stb_d;
  logic             dwell_q, dwell_d;
  logic             ill_q;
  logic             an_error_q, an_error_d;
  logic             capture;

  always_comb begin
    stb_d = '0;
    if (legal && same) begin
      stb_d = (stb_q == STB_SAT) ? stb_q : stb_q + STB_W'(1);
    end
    capture    = legal && same && (stb_d == STB_CAP) && !dwell_q;
    dwell_d    = dwell_q;
    if (!same)        dwell_d = 1'b0;
    else if (capture) dwell_d = 1'b1;
    an_error_d = illegal && !ill_q;
  end

  always_ff @(posedge basys_clock or negedge rst_n) begin
    if (!rst_n) begin
      stb_q      <= '0;
      dwell_q    <= 1'b0;
      ill_q      <= 1'b0;
      an_error_q <= 1'b0;
    end else begin
      stb_q      <= stb_d;
      dwell_q    <= dwell_d;
      ill_q      <= illegal;
      an_error_q <= an_error_d;
    end
  end

  // Stale watchdog: a capture in the timeout cycle wins and suppresses the timeout
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stale_q, stale_d;
  logic             timeout;

  always_comb begin
    cnt_d   = cnt_q;
    stale_d = stale_q;
    timeout = 1'b0;
    if (capture) begin
      cnt_d   = '0;
      stale_d = 1'b0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LIMIT_M1) begin
        timeout = 1'b1;
        stale_d = 1'b1;
      end
    end
  end

  // Slot store: raw byte and decoded code per digit position, plus captured bits
  logic [3:0][7:0] slot_seg_q, slot_seg_d;
  logic [3:0][4:0] slot_code_q, slot_code_d;
  logic [3:0]      slot_vld_q, slot_vld_d;
  logic            publish;

  always_comb begin
    publish     = &slot_vld_q;
    slot_seg_d  = slot_seg_q;
    slot_code_d = slot_code_q;
    slot_vld_d  = slot_vld_q;
    if (publish || timeout) slot_vld_d = '0;
    if (capture) begin
      slot_seg_d[slot]  = seg_p0_q;
      slot_code_d[slot] = decode_seg(seg_p0_q[6:0]);
      slot_vld_d[slot]  = 1'b1;
    end
  end

  // Publish and scroll check against the previously published codes
  logic [3:0][4:0] prev_q, prev_d;
  logic [19:0]     digit_code_q, digit_code_d;
  logic [31:0]     frame_seg_q, frame_seg_d;
  logic            frame_valid_d, scroll_step_d;
  logic            frame_valid_q, scroll_step_q;
  logic            bad_q, bad_d;
  logic [7:0]      scroll_count_q, scroll_count_d;
  logic            shift_match;

  always_comb begin
    shift_match    = (slot_code_q[3] == prev_q[2]) &&
                     (slot_code_q[2] == prev_q[1]) &&
                     (slot_code_q[1] == prev_q[0]);
    prev_d         = prev_q;
    digit_code_d   = digit_code_q;
    frame_seg_d    = frame_seg_q;
    bad_d          = bad_q;
    scroll_count_d = scroll_count_q;
    frame_valid_d  = 1'b0;
    scroll_step_d  = 1'b0;
    if (publish) begin
      frame_valid_d = 1'b1;
      digit_code_d  = slot_code_q;
      frame_seg_d   = slot_seg_q;
      bad_d         = has_bad(slot_code_q);
      prev_d        = slot_code_q;
      if (shift_match && (slot_code_q != prev_q)) begin
        scroll_step_d  = 1'b1;
        scroll_count_d = scroll_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge basys_clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      stale_q        <= 1'b0;
      slot_seg_q     <= {4{8'hFF}};
      slot_code_q    <= {4{CODE_BLK}};
      slot_vld_q     <= '0;
      prev_q         <= {4{CODE_BLK}};
      digit_code_q   <= 20'hFFFFF;
      frame_seg_q    <= 32'hFFFFFFFF;
      frame_valid_q  <= 1'b0;
      scroll_step_q  <= 1'b0;
      bad_q          <= 1'b0;
      scroll_count_q <= 8'd0;
    end else begin
      cnt_q          <= cnt_d;
      stale_q        <= stale_d;
      slot_seg_q     <= slot_seg_d;
      slot_code_q    <= slot_code_d;
      slot_vld_q     <= slot_vld_d;
      prev_q         <= prev_d;
      digit_code_q   <= digit_code_d;
      frame_seg_q    <= frame_seg_d;
      frame_valid_q  <= frame_valid_d;
      scroll_step_q  <= scroll_step_d;
      bad_q          <= bad_d;
      scroll_count_q <= scroll_count_d;
    end
  end

  assign bus.digit_code   = digit_code_q;
  assign bus.frame_seg    = frame_seg_q;
  assign bus.frame_valid  = frame_valid_q;
  assign bus.scroll_step  = scroll_step_q;
  assign bus.bad_pattern  = bad_q;
  assign bus.an_error     = an_error_q;
  assign bus.stale        = stale_q;
  assign bus.scroll_count = scroll_count_q;

endmodule
